// File: rtl/ir_sweep_sched.sv
// ir_sweep_sched: shares one A2D between periodic IR sensor sweeps and
// on-demand battery conversions; IR sweeps win arbitration.
module ir_sweep_sched #(
  parameter int unsigned PERIOD_CYCLES = 2097152,
  parameter int unsigned SETTLE_CYCLES = 4096,
  parameter logic [3:0]  BATT_CH       = 4'd8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        batt_req,
  input  logic        cnv_cmplt,
  input  logic [11:0] res,
  input  logic [2:0]  rd_sel,
  output logic        strt_cnv,
  output logic [3:0]  chnnl,
  output logic        IR_en,
  output logic        IR_vld,
  output logic [11:0] rd_dat,
  output logic [11:0] batt,
  output logic        batt_vld
);

  localparam int unsigned TMR_W  = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;
  localparam int unsigned STL_W  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int unsigned RES_W  = 12;
  localparam int unsigned NUM_IR = 8;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(PERIOD_CYCLES - 1);
  localparam logic [STL_W-1:0] STL_LAST = STL_W'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SETTLE, IR_CNV, BATT} state_t;

  state_t             state, state_nxt;
  logic [TMR_W-1:0]   timer;
  logic [STL_W-1:0]   settle_cnt, settle_nxt;
  logic [2:0]         ch, ch_nxt;
  logic               batt_pend;
  logic               tick, settle_done;
  logic               strt_nxt, ir_en_nxt, ir_vld_nxt, batt_vld_nxt;
  logic [3:0]         chnnl_nxt;
  logic               ir_wr, batt_wr, batt_take;
  logic [RES_W-1:0]   ir_reg [NUM_IR];

  assign tick        = (timer == TMR_LAST);
  assign settle_done = (settle_cnt == STL_LAST);
  assign rd_dat      = ir_reg[rd_sel];

  // Free-running sweep period timer
  always_ff @(posedge clk) begin
    if (!rst_n)    timer <= '0;
    else if (tick) timer <= '0;
    else           timer <= timer + TMR_W'(1);
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; ticks outside IDLE are dropped
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (tick)           state_nxt = SETTLE;
        else if (batt_pend) state_nxt = BATT;
      end
      SETTLE:  if (settle_done) state_nxt = IR_CNV;
      IR_CNV:  if (cnv_cmplt && (ch == 3'd7)) state_nxt = IDLE;
      BATT:    if (cnv_cmplt) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output/datapath control: next values of the registered outputs
  always_comb begin
    strt_nxt     = 1'b0;
    ir_vld_nxt   = 1'b0;
    batt_vld_nxt = 1'b0;
    ir_en_nxt    = IR_en;
    chnnl_nxt    = chnnl;
    ch_nxt       = ch;
    settle_nxt   = settle_cnt;
    ir_wr        = 1'b0;
    batt_wr      = 1'b0;
    batt_take    = 1'b0;
    case (state)
      IDLE: begin
        if (tick) begin
          ir_en_nxt  = 1'b1;
          ch_nxt     = '0;
          settle_nxt = '0;
        end else if (batt_pend) begin
          strt_nxt  = 1'b1;
          chnnl_nxt = BATT_CH;
          batt_take = 1'b1;
        end
      end
      SETTLE: begin
        settle_nxt = settle_cnt + STL_W'(1);
        if (settle_done) begin
          strt_nxt  = 1'b1;
          chnnl_nxt = {1'b0, ch};
        end
      end
      IR_CNV: begin
        if (cnv_cmplt) begin
          ir_wr = 1'b1;
          if (ch != 3'd7) begin
            ch_nxt    = ch + 3'd1;
            strt_nxt  = 1'b1;
            chnnl_nxt = {1'b0, ch + 3'd1};
          end else begin
            ir_vld_nxt = 1'b1;
            ir_en_nxt  = 1'b0;
          end
        end
      end
      BATT: begin
        if (cnv_cmplt) begin
          batt_wr      = 1'b1;
          batt_vld_nxt = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Registered outputs, channel/settle counters, battery result and request flag
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      strt_cnv   <= 1'b0;
      chnnl      <= '0;
      IR_en      <= 1'b0;
      IR_vld     <= 1'b0;
      batt_vld   <= 1'b0;
      ch         <= '0;
      settle_cnt <= '0;
      batt_pend  <= 1'b0;
      batt       <= '0;
    end else begin
      strt_cnv   <= strt_nxt;
      chnnl      <= chnnl_nxt;
      IR_en      <= ir_en_nxt;
      IR_vld     <= ir_vld_nxt;
      batt_vld   <= batt_vld_nxt;
      ch         <= ch_nxt;
      settle_cnt <= settle_nxt;
      // A request in the BATT-entry cycle keeps the flag set
      batt_pend  <= batt_req | (batt_pend & ~batt_take);
      if (batt_wr) batt <= res;
    end
  end

  // IR result register file, written in place as each channel completes
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_IR; i++) ir_reg[i] <= '0;
    end else if (ir_wr) begin
      ir_reg[ch] <= res;
    end
  end

endmodule

// File: tb/tb_ir_sweep_sched.sv
// Bench for ir_sweep_sched: A2D responder, abstract cycle model with
// per-cycle compare, and directed scenario checks.
module tb_ir_sweep_sched;

  localparam int unsigned P   = 64;
  localparam int unsigned S   = 4;
  localparam logic [3:0]  BCH = 4'd8;
  localparam int          LAT = 10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        batt_req = 1'b0;
  logic        cnv_cmplt = 1'b0;
  logic [11:0] res = '0;
  logic [2:0]  rd_sel = '0;
  logic        strt_cnv;
  logic [3:0]  chnnl;
  logic        IR_en;
  logic        IR_vld;
  logic [11:0] rd_dat;
  logic [11:0] batt;
  logic        batt_vld;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  ir_sweep_sched #(.PERIOD_CYCLES(P), .SETTLE_CYCLES(S), .BATT_CH(BCH)) dut (
    .clk(clk), .rst_n(rst_n), .batt_req(batt_req), .cnv_cmplt(cnv_cmplt),
    .res(res), .rd_sel(rd_sel), .strt_cnv(strt_cnv), .chnnl(chnnl),
    .IR_en(IR_en), .IR_vld(IR_vld), .rd_dat(rd_dat), .batt(batt),
    .batt_vld(batt_vld)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic nxt();
    @(negedge clk);
    #1;
  endtask

  // A2D responder: completes LAT cycles after strt_cnv, IR result 0x100+chnnl
  int          cd = 0;
  logic [11:0] a2d_val = '0;
  logic [11:0] batt_val = 12'hABC;
  bit          kill_a2d = 1'b0;
  bit          inj_stale = 1'b0;

  always @(negedge clk) begin
    cnv_cmplt = 1'b0;
    if (kill_a2d) begin
      cd = 0;
      kill_a2d = 1'b0;
    end
    if (cd > 0) begin
      cd--;
      if (cd == 0) begin
        cnv_cmplt = 1'b1;
        res = a2d_val;
      end
    end
    if (inj_stale) begin
      cnv_cmplt = 1'b1;
      res = 12'hFFF;
      inj_stale = 1'b0;
    end
    if (strt_cnv) begin
      cd = LAT;
      a2d_val = (chnnl == BCH) ? batt_val : 12'h100 + 12'(chnnl);
    end
  end

  // Behavioural model: who owns the A2D, settle countdown, channel cursor
  int          m_t = 0;
  bit          sw_on = 1'b0;
  bit          bt_on = 1'b0;
  int          settle_left = 0;
  int          cur_ch = 0;
  bit          pend = 1'b0;
  bit          m_tick, m_took;
  logic        e_strt = 1'b0, e_ir_en = 1'b0, e_irv = 1'b0, e_bv = 1'b0;
  logic [3:0]  e_chnnl = '0;
  logic [11:0] e_batt = '0;
  logic [11:0] e_ir [8];

  always @(posedge clk) begin
    if (!rst_n) begin
      m_t = 0; sw_on = 0; bt_on = 0; settle_left = 0; cur_ch = 0; pend = 0;
      e_strt = 0; e_ir_en = 0; e_irv = 0; e_bv = 0; e_chnnl = '0; e_batt = '0;
      for (int i = 0; i < 8; i++) e_ir[i] = '0;
    end else begin
      m_tick = (m_t == P - 1);
      m_t    = m_tick ? 0 : m_t + 1;
      m_took = 1'b0;
      e_strt = 0; e_irv = 0; e_bv = 0;
      if (!sw_on && !bt_on) begin
        if (m_tick) begin
          sw_on = 1; settle_left = S; cur_ch = 0; e_ir_en = 1;
        end else if (pend) begin
          bt_on = 1; m_took = 1; e_strt = 1; e_chnnl = BCH;
        end
      end else if (sw_on && settle_left > 0) begin
        settle_left--;
        if (settle_left == 0) begin
          e_strt = 1; e_chnnl = 4'd0;
        end
      end else if (sw_on) begin
        if (cnv_cmplt) begin
          e_ir[cur_ch] = res;
          if (cur_ch < 7) begin
            cur_ch++; e_strt = 1; e_chnnl = 4'(cur_ch);
          end else begin
            e_irv = 1; e_ir_en = 0; sw_on = 0;
          end
        end
      end else if (cnv_cmplt) begin
        e_batt = res; e_bv = 1; bt_on = 0;
      end
      pend = batt_req | (pend & !m_took);
    end
  end

  // Per-cycle compare against the model
  always @(posedge clk) begin
    #1;
    chk("strt_cnv", strt_cnv, e_strt);
    chk("chnnl", chnnl, e_chnnl);
    chk("IR_en", IR_en, e_ir_en);
    chk("IR_vld", IR_vld, e_irv);
    chk("batt_vld", batt_vld, e_bv);
    chk("batt", batt, e_batt);
    chk("rd_dat", rd_dat, e_ir[rd_sel]);
  end

  // Event monitor: start log, pulse counts, in-order sweep check
  int strt_log[$];
  int strt_cyc[$];
  int irv_cnt = 0, bv_cnt = 0, ir_en_rise = 0, ir_en_rise_cyc = 0, sw_idx = 0;
  bit ir_en_q = 1'b0, ir_en_seen = 1'b0;

  always @(negedge clk) begin
    if (strt_cnv === 1'b1) begin
      strt_log.push_back(int'(chnnl));
      strt_cyc.push_back(cyc);
      if (IR_en) begin
        chk("sweep_order", chnnl, sw_idx);
        sw_idx++;
      end
    end
    if (IR_vld === 1'b1) begin
      irv_cnt++;
      chk("sweep_len", sw_idx, 8);
      sw_idx = 0;
    end
    if (batt_vld === 1'b1) bv_cnt++;
    if (IR_en === 1'b1 && !ir_en_q) begin
      ir_en_rise++;
      ir_en_rise_cyc = cyc;
    end
    if (IR_en === 1'b1) ir_en_seen = 1'b1;
    ir_en_q = (IR_en === 1'b1);
  end

  int base, bv0, irv0, vld_cyc, nlog;
  bit found;

  initial begin
    // Reset state
    repeat (3) nxt();
    chk("rst_IR_en", IR_en, 0);
    chk("rst_strt", strt_cnv, 0);
    chk("rst_chnnl", chnnl, 0);
    chk("rst_batt", batt, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      rd_sel = 3'(i);
      nxt();
      chk("rst_rd_dat", rd_dat, 0);
    end

    // Battery only
    batt_req = 1'b1; nxt(); batt_req = 1'b0;
    found = 0;
    for (int k = 0; k < 40 && !found; k++) begin
      if (batt_vld) found = 1; else nxt();
    end
    chk("batt_vld_seen", found, 1);
    nxt();
    chk("batt_value", batt, 12'hABC);
    chk("batt_vld_count", bv_cnt, 1);
    chk("batt_starts", strt_log.size(), 1);
    if (strt_log.size() >= 1) chk("batt_chnnl", strt_log[0], 8);
    chk("batt_IR_en_low", ir_en_seen, 0);

    // Back-to-back requests, second in the BATT-entry cycle: two conversions
    batt_val = 12'h321;
    bv0 = bv_cnt;
    batt_req = 1'b1; nxt(); nxt(); batt_req = 1'b0;
    for (int k = 0; k < 60 && bv_cnt < bv0 + 2; k++) nxt();
    repeat (3) nxt();
    chk("double_req_count", bv_cnt - bv0, 2);
    chk("double_req_batt", batt, 12'h321);

    // Basic sweep, settle timing, dropped tick
    base = strt_log.size();
    found = 0;
    for (int k = 0; k < 300 && !found; k++) begin
      if (IR_vld) found = 1; else nxt();
    end
    chk("sweep_vld_seen", found, 1);
    nxt();
    chk("sweep_IR_en_low", IR_en, 0);
    chk("sweep_vld_count", irv_cnt, 1);
    chk("sweep_starts", strt_log.size() - base, 8);
    if (strt_log.size() >= base + 8) begin
      for (int i = 0; i < 8; i++) chk("sweep_chan", strt_log[base + i], i);
      chk("settle_gap", strt_cyc[base] - ir_en_rise_cyc, 4);
    end
    chk("dropped_tick", ir_en_rise, 1);
    for (int i = 0; i < 8; i++) begin
      rd_sel = 3'(i);
      nxt();
      chk("sweep_rd_dat", rd_dat, 12'h100 + i);
    end

    // Collision: batt_pend and tick in the same IDLE cycle, plus a mid-sweep request
    batt_val = 12'h5A5;
    found = 0;
    for (int k = 0; k < 200 && !found; k++) begin
      if (m_t == P - 2) found = 1; else nxt();
    end
    chk("collision_align", found, 1);
    base = strt_log.size(); bv0 = bv_cnt; irv0 = irv_cnt;
    batt_req = 1'b1; nxt(); batt_req = 1'b0;
    repeat (30) nxt();
    batt_req = 1'b1; nxt(); batt_req = 1'b0;
    found = 0;
    for (int k = 0; k < 200 && !found; k++) begin
      if (IR_vld) found = 1; else nxt();
    end
    chk("collision_vld_seen", found, 1);
    vld_cyc = cyc;
    for (int k = 0; k < 40 && !batt_vld; k++) nxt();
    repeat (15) nxt();
    chk("collision_vld_count", irv_cnt - irv0, 1);
    chk("collision_batt_count", bv_cnt - bv0, 1);
    chk("collision_starts", strt_log.size() - base, 9);
    if (strt_log.size() >= base + 9) begin
      chk("collision_first_ch", strt_log[base], 0);
      chk("collision_batt_ch", strt_log[base + 8], 8);
      chk("collision_batt_gap", strt_cyc[base + 8] - vld_cyc, 1);
    end
    chk("collision_batt", batt, 12'h5A5);

    // Reset right after the ch3 completion, then a stale completion
    found = 0;
    for (int k = 0; k < 400 && !found; k++) begin
      if (cnv_cmplt && IR_en && chnnl == 4'd3) found = 1; else nxt();
    end
    chk("ch3_cmplt_seen", found, 1);
    nxt();
    rst_n = 1'b0; kill_a2d = 1'b1; irv0 = irv_cnt;
    nxt();
    rst_n = 1'b1; sw_idx = 0;
    repeat (2) nxt();
    inj_stale = 1'b1;
    nlog = strt_log.size();
    repeat (3) nxt();
    chk("abort_IR_en", IR_en, 0);
    chk("abort_chnnl", chnnl, 0);
    chk("abort_batt", batt, 0);
    for (int i = 0; i < 8; i++) begin
      rd_sel = 3'(i);
      nxt();
      chk("abort_rd_dat", rd_dat, 0);
    end
    chk("abort_no_vld", irv_cnt - irv0, 0);
    chk("abort_idle", strt_log.size() - nlog, 0);

    repeat (5) nxt();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
